// File: rtl/fpu_arbiter_pkg.sv
// Shared constants for the FPU arbiter: operand/command widths, FPU operator codes,
// arbiter state encoding and the owner-ID width helper.
package fpu_arbiter_pkg;

  localparam int C_OP_DEF  = 32;
  localparam int C_CMD_DEF = 4;
  localparam int C_RM_DEF  = 2;

  localparam logic [3:0] CMD_ADD    = 4'h0;
  localparam logic [3:0] CMD_SUB    = 4'h1;
  localparam logic [3:0] CMD_MUL    = 4'h2;
  localparam logic [3:0] CMD_DIV    = 4'h3;
  localparam logic [3:0] CMD_I2F    = 4'h4;
  localparam logic [3:0] CMD_F2I    = 4'h5;
  localparam logic [3:0] CMD_SQRT   = 4'h6;
  localparam logic [3:0] CMD_NOP    = 4'h7;
  localparam logic [3:0] CMD_FMADD  = 4'h8;
  localparam logic [3:0] CMD_FMSUB  = 4'h9;
  localparam logic [3:0] CMD_FNMADD = 4'hA;
  localparam logic [3:0] CMD_FNMSUB = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // A single requester still needs a one-bit owner ID.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fpu_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request searching upward from
// last_grant+1 (wrapping), reusable by any shared-unit arbiter.
module fpu_arbiter_rr_picker
  import fpu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_id_o,
  output logic               any_valid_o
);

  logic            found;
  logic [ID_W-1:0] cand;

  always_comb begin
    grant_o     = '0;
    grant_id_o  = '0;
    any_valid_o = |req_i;
    found       = 1'b0;
    cand        = '0;
    // Offset NUM_REQ wraps back onto last_grant itself, so it is searched last.
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(last_grant_i) + i) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found      = 1'b1;
        grant_id_o = cand;
      end
    end
    if (found) begin
      grant_o[grant_id_o] = 1'b1;
    end
  end

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one FPU between NUM_REQ requesters: round-robin accept in IDLE, FPU
// enable held through BUSY, result returned to the owner in RESP.
module fpu_arbiter
  import fpu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int C_OP    = C_OP_DEF,
  parameter int C_CMD   = C_CMD_DEF,
  parameter int C_RM    = C_RM_DEF,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*C_OP-1:0]  req_op_a_i,
  input  logic [NUM_REQ*C_OP-1:0]  req_op_b_i,
  input  logic [NUM_REQ*C_RM-1:0]  req_rm_i,
  input  logic [NUM_REQ*C_CMD-1:0] req_cmd_i,
  output logic [NUM_REQ-1:0]       resp_valid_o,
  output logic [C_OP-1:0]          resp_result_o,
  input  logic                    stall_i,
  output logic                    busy_o,
  output logic [ID_W-1:0]          owner_o,
  output logic [C_OP-1:0]          fpu_operand_a_o,
  output logic [C_OP-1:0]          fpu_operand_b_o,
  output logic [C_RM-1:0]          fpu_rounding_mode_o,
  output logic [C_CMD-1:0]         fpu_operator_o,
  output logic                    fpu_enable_o,
  output logic                    fpu_stall_o,
  input  logic [C_OP-1:0]          fpu_result_i,
  input  logic                    fpu_ready_i,
  input  logic                    fpu_result_valid_i
);

  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [C_OP-1:0]    op_a_q, op_a_d;
  logic [C_OP-1:0]    op_b_q, op_b_d;
  logic [C_RM-1:0]    rm_q, rm_d;
  logic [C_CMD-1:0]   cmd_q, cmd_d;
  logic [C_OP-1:0]    result_q, result_d;
  logic               enable_q, enable_d;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_id;
  logic               pick_any;
  logic               accept;
  logic [C_OP-1:0]    sel_a, sel_b;
  logic [C_RM-1:0]    sel_rm;
  logic [C_CMD-1:0]   sel_cmd;

  fpu_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_i        (req_valid_i),
    .last_grant_i (last_grant_q),
    .grant_o      (pick_grant),
    .grant_id_o   (pick_id),
    .any_valid_o  (pick_any)
  );

  assign accept      = (state_q == ST_IDLE) && fpu_ready_i && pick_any;
  assign req_ready_o = accept ? pick_grant : '0;

  // Payload mux uses constant slice offsets only.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_rm  = '0;
    sel_cmd = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_id == ID_W'(k)) begin
        sel_a   = req_op_a_i[k*C_OP +: C_OP];
        sel_b   = req_op_b_i[k*C_OP +: C_OP];
        sel_rm  = req_rm_i[k*C_RM +: C_RM];
        sel_cmd = req_cmd_i[k*C_CMD +: C_CMD];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    rm_d         = rm_q;
    cmd_d        = cmd_q;
    result_d     = result_q;
    enable_d     = enable_q;
    resp_valid_d = resp_valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d      = ST_BUSY;
          owner_d      = pick_id;
          last_grant_d = pick_id;
          op_a_d       = sel_a;
          op_b_d       = sel_b;
          rm_d         = sel_rm;
          cmd_d        = sel_cmd;
          enable_d     = 1'b1;
        end
      end
      // A stalled FPU may already show result_valid; wait for the stall to lift.
      ST_BUSY: begin
        if (fpu_result_valid_i && !stall_i) begin
          state_d               = ST_RESP;
          result_d              = fpu_result_i;
          enable_d              = 1'b0;
          resp_valid_d          = '0;
          resp_valid_d[owner_q] = 1'b1;
        end
      end
      ST_RESP: begin
        if (!stall_i) begin
          state_d      = ST_IDLE;
          resp_valid_d = '0;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        enable_d     = 1'b0;
        resp_valid_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      op_a_q       <= '0;
      op_b_q       <= '0;
      rm_q         <= '0;
      cmd_q        <= '0;
      result_q     <= '0;
      enable_q     <= 1'b0;
      resp_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      rm_q         <= rm_d;
      cmd_q        <= cmd_d;
      result_q     <= result_d;
      enable_q     <= enable_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign resp_valid_o        = resp_valid_q;
  assign resp_result_o       = result_q;
  assign busy_o              = (state_q != ST_IDLE);
  assign owner_o             = owner_q;
  assign fpu_operand_a_o     = op_a_q;
  assign fpu_operand_b_o     = op_b_q;
  assign fpu_rounding_mode_o = rm_q;
  assign fpu_operator_o      = cmd_q;
  assign fpu_enable_o        = enable_q;
  assign fpu_stall_o         = stall_i;

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready_o));
  a_resp_onehot:  assert property (@(posedge clk) disable iff (rst) $onehot0(resp_valid_o));
  a_ready_idle:   assert property (@(posedge clk) disable iff (rst)
                                   (req_ready_o != '0) |-> (state_q == ST_IDLE));

endmodule

// File: tb/tb_fpu_arbiter.sv
// Self-checking bench for fpu_arbiter: transaction-level reference model compared
// every cycle, a simple FPU stand-in, and directed scenarios with literal checks.
module tb_fpu_arbiter;
  import fpu_arbiter_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int C_OP    = 32;
  localparam int C_CMD   = 4;
  localparam int C_RM    = 2;
  localparam int ID_W    = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]       req_valid, req_ready, resp_valid;
  logic [NUM_REQ*C_OP-1:0]  req_op_a, req_op_b;
  logic [NUM_REQ*C_RM-1:0]  req_rm;
  logic [NUM_REQ*C_CMD-1:0] req_cmd;
  logic [C_OP-1:0]          resp_result, fpu_a, fpu_b, fpu_result;
  logic [C_RM-1:0]          fpu_rm;
  logic [C_CMD-1:0]         fpu_cmd;
  logic [ID_W-1:0]          owner;
  logic stall, busy, fpu_enable, fpu_stall, fpu_ready, fpu_rv, spurious;

  logic [C_OP-1:0]  pa [NUM_REQ];
  logic [C_OP-1:0]  pb [NUM_REQ];
  logic [C_RM-1:0]  prm [NUM_REQ];
  logic [C_CMD-1:0] pcmd [NUM_REQ];
  int left [NUM_REQ];
  int seq [NUM_REQ];
  int resp_done [NUM_REQ];
  int grants [$];

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_on = 1'b0;
  logic [NUM_REQ-1:0] acc_q = '0;

  always_comb begin
    req_op_a = '0;
    req_op_b = '0;
    req_rm   = '0;
    req_cmd  = '0;
    for (int k3 = 0; k3 < NUM_REQ; k3++) begin
      req_op_a[k3*C_OP +: C_OP]   = pa[k3];
      req_op_b[k3*C_OP +: C_OP]   = pb[k3];
      req_rm[k3*C_RM +: C_RM]     = prm[k3];
      req_cmd[k3*C_CMD +: C_CMD]  = pcmd[k3];
    end
  end

  fpu_arbiter #(
    .NUM_REQ (NUM_REQ), .C_OP (C_OP), .C_CMD (C_CMD), .C_RM (C_RM), .ID_W (ID_W)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid_i         (req_valid),
    .req_ready_o         (req_ready),
    .req_op_a_i          (req_op_a),
    .req_op_b_i          (req_op_b),
    .req_rm_i            (req_rm),
    .req_cmd_i           (req_cmd),
    .resp_valid_o        (resp_valid),
    .resp_result_o       (resp_result),
    .stall_i             (stall),
    .busy_o              (busy),
    .owner_o             (owner),
    .fpu_operand_a_o     (fpu_a),
    .fpu_operand_b_o     (fpu_b),
    .fpu_rounding_mode_o (fpu_rm),
    .fpu_operator_o      (fpu_cmd),
    .fpu_enable_o        (fpu_enable),
    .fpu_stall_o         (fpu_stall),
    .fpu_result_i        (fpu_result),
    .fpu_ready_i         (fpu_ready),
    .fpu_result_valid_i  (fpu_rv)
  );

  // Stand-in FPU arithmetic: one exact float case, otherwise a traceable integer mix.
  function automatic logic [31:0] fake_fpu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] cmd);
    if (cmd == CMD_ADD && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    return a + b + {28'd0, cmd};
  endfunction

  // FPU stand-in: result_valid on the second enabled cycle, counter frozen by stall.
  logic [1:0] fcnt;
  always @(posedge clk) begin
    if (rst || !fpu_enable) fcnt <= 2'd0;
    else if (!fpu_stall && fcnt != 2'd3) fcnt <= fcnt + 2'd1;
  end
  assign fpu_rv     = (fpu_enable && fcnt == 2'd1) || spurious;
  assign fpu_result = fake_fpu(fpu_a, fpu_b, fpu_cmd);

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 operating, 2 returning a result.
  int m_phase = 0;
  int m_owner = 0;
  int m_last  = NUM_REQ - 1;
  logic [C_OP-1:0]  m_a = '0, m_b = '0, m_result = '0;
  logic [C_RM-1:0]  m_rm = '0;
  logic [C_CMD-1:0] m_cmd = '0;
  int pick, kk;
  logic [NUM_REQ-1:0] exp_ready, exp_resp;

  always @(negedge clk) begin
    if (chk_on) begin
      pick = -1;
      if (m_phase == 0 && fpu_ready) begin
        for (int i = 1; i <= NUM_REQ; i++) begin
          kk = (m_last + i) % NUM_REQ;
          if (pick < 0 && req_valid[kk]) pick = kk;
        end
      end
      exp_ready = '0;
      if (pick >= 0) exp_ready[pick] = 1'b1;
      exp_resp = '0;
      if (m_phase == 2) exp_resp[m_owner] = 1'b1;

      checkOutput("req_ready", req_ready, exp_ready);
      checkOutput("resp_valid", resp_valid, exp_resp);
      checkOutput("fpu_enable", fpu_enable, m_phase == 1);
      checkOutput("busy", busy, m_phase != 0);
      checkOutput("owner", owner, m_owner);
      checkOutput("fpu_stall", fpu_stall, stall);
      checkOutput("fpu_op_a", fpu_a, m_a);
      checkOutput("fpu_op_b", fpu_b, m_b);
      checkOutput("fpu_rm", fpu_rm, m_rm);
      checkOutput("fpu_cmd", fpu_cmd, m_cmd);
      if (m_phase == 2) checkOutput("resp_result", resp_result, m_result);

      acc_q = req_ready & req_valid;

      if (rst) begin
        m_phase = 0; m_owner = 0; m_last = NUM_REQ - 1;
        m_a = '0; m_b = '0; m_rm = '0; m_cmd = '0; m_result = '0;
      end else begin
        case (m_phase)
          0: if (pick >= 0) begin
               m_phase = 1; m_owner = pick; m_last = pick;
               m_a = pa[pick]; m_b = pb[pick]; m_rm = prm[pick]; m_cmd = pcmd[pick];
             end
          1: if (fpu_rv && !stall) begin
               m_phase = 2; m_result = fake_fpu(m_a, m_b, m_cmd);
             end
          default: if (!stall) begin
               m_phase = 0; resp_done[m_owner]++;
             end
        endcase
      end
    end
  end

  task automatic applyStimulus(input int k, input logic [3:0] cmd, input logic [31:0] a,
                               input logic [31:0] b, input logic [1:0] rm);
    pa[k] = a; pb[k] = b; prm[k] = rm; pcmd[k] = cmd;
    req_valid[k] = 1'b1;
  endtask

  // Advance to just after the next rising edge; requesters react to last cycle's accept.
  task automatic step();
    @(posedge clk);
    #1;
    for (int k2 = 0; k2 < NUM_REQ; k2++) begin
      if (acc_q[k2]) begin
        grants.push_back(k2);
        if (left[k2] > 0) begin
          left[k2]--;
          seq[k2]++;
          applyStimulus(k2, CMD_MUL, C_OP'(32'h1000 * (k2 + 1) + seq[k2]), C_OP'(seq[k2]),
                        C_RM'(seq[k2]));
        end else begin
          req_valid[k2] = 1'b0;
        end
      end
    end
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((req_valid != '0 || m_phase != 0) && n < bound) begin
      step();
      n++;
    end
    if (n >= bound) checkOutput("drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    req_valid = '0; stall = 1'b0; spurious = 1'b0; fpu_ready = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      pa[k] = '0; pb[k] = '0; prm[k] = '0; pcmd[k] = '0;
      left[k] = 0; seq[k] = 0; resp_done[k] = 0;
    end
    @(posedge clk); #1;
    chk_on = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_enable", fpu_enable, 1'b0);
    checkOutput("rst_resp", resp_valid, 2'b00);
    checkOutput("rst_owner", owner, 1'b0);
    checkOutput("rst_result", resp_result, 32'h0);

    $display("[TB] single ADD from requester 0");
    step();
    applyStimulus(0, CMD_ADD, 32'h3F800000, 32'h40000000, 2'd0);
    @(negedge clk); checkOutput("t1_c0_ready", req_ready, 2'b01);
    step(); @(negedge clk); checkOutput("t1_c1_enable", fpu_enable, 1'b1);
    step(); @(negedge clk); checkOutput("t1_c2_enable", fpu_enable, 1'b1);
    step(); @(negedge clk);
    checkOutput("t1_c3_resp", resp_valid, 2'b01);
    checkOutput("t1_c3_result", resp_result, 32'h40400000);
    step(); @(negedge clk); checkOutput("t1_c4_busy", busy, 1'b0);

    $display("[TB] contention, both requesters issuing MUL");
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    grants.delete();
    for (int k = 0; k < NUM_REQ; k++) begin resp_done[k] = 0; left[k] = 3; seq[k] = 0; end
    applyStimulus(0, CMD_MUL, 32'h00001000, 32'h00000007, 2'd1);
    applyStimulus(1, CMD_MUL, 32'h00002000, 32'h00000009, 2'd2);
    @(negedge clk); checkOutput("t2_first_ready", req_ready, 2'b01);
    drain(100);
    checkOutput("t2_num_grants", grants.size(), 8);
    checkOutput("t2_grant0", grants[0], 0);
    checkOutput("t2_grant1", grants[1], 1);
    checkOutput("t2_grant2", grants[2], 0);
    checkOutput("t2_grant3", grants[3], 1);
    checkOutput("t2_done0", resp_done[0], 4);
    checkOutput("t2_done1", resp_done[1], 4);

    $display("[TB] stall in operation and in response");
    applyStimulus(1, CMD_SUB, 32'h00000010, 32'h00000020, 2'd1);
    @(negedge clk); checkOutput("t3_c0_ready", req_ready, 2'b10);
    step();
    step(); stall = 1'b1;
    @(negedge clk);
    checkOutput("t3_c2_enable", fpu_enable, 1'b1);
    checkOutput("t3_c2_stall", fpu_stall, 1'b1);
    checkOutput("t3_c2_op_a", fpu_a, 32'h00000010);
    step(); @(negedge clk); checkOutput("t3_c3_resp", resp_valid, 2'b00);
    step();
    step(); stall = 1'b0;
    @(negedge clk); checkOutput("t3_c5_resp", resp_valid, 2'b00);
    step(); stall = 1'b1;
    @(negedge clk);
    checkOutput("t3_c6_resp", resp_valid, 2'b10);
    checkOutput("t3_c6_result", resp_result, 32'h00000031);
    step(); @(negedge clk); checkOutput("t3_c7_resp", resp_valid, 2'b10);
    step(); stall = 1'b0;
    @(negedge clk); checkOutput("t3_c8_resp", resp_valid, 2'b10);
    step(); @(negedge clk);
    checkOutput("t3_c9_resp", resp_valid, 2'b00);
    checkOutput("t3_c9_busy", busy, 1'b0);

    $display("[TB] FPU not ready in idle");
    fpu_ready = 1'b0;
    applyStimulus(1, CMD_DIV, 32'h00000100, 32'h00000003, 2'd3);
    @(negedge clk); checkOutput("t4_c0_ready", req_ready, 2'b00);
    step(); @(negedge clk); checkOutput("t4_c1_ready", req_ready, 2'b00);
    step(); fpu_ready = 1'b1;
    @(negedge clk); checkOutput("t4_c2_ready", req_ready, 2'b10);
    drain(20);

    $display("[TB] reset during operation");
    applyStimulus(0, CMD_ADD, 32'h00000005, 32'h00000006, 2'd0);
    @(negedge clk); checkOutput("t5_c0_ready", req_ready, 2'b01);
    step(); rst = 1'b1;
    @(negedge clk); checkOutput("t5_c1_enable", fpu_enable, 1'b1);
    step(); rst = 1'b0;
    applyStimulus(0, CMD_MUL, 32'h00000002, 32'h00000003, 2'd0);
    applyStimulus(1, CMD_MUL, 32'h00000004, 32'h00000005, 2'd0);
    @(negedge clk);
    checkOutput("t5_c2_enable", fpu_enable, 1'b0);
    checkOutput("t5_c2_resp", resp_valid, 2'b00);
    checkOutput("t5_c2_busy", busy, 1'b0);
    checkOutput("t5_c2_ready", req_ready, 2'b01);
    drain(40);

    $display("[TB] spurious result_valid in idle");
    spurious = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("t6_resp", resp_valid, 2'b00);
      checkOutput("t6_busy", busy, 1'b0);
      step();
    end
    spurious = 1'b0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
Shares one riscv_fpu instance between NUM_REQ requesters, for example several cores or an APU port plus a debug port. It does the following:
- Accepts one operation at a time using a valid/ready handshake.
- Picks the next requester with round-robin arbitration.
- Holds the FPU enable for the whole operation.
- Routes the result back to the requester that issued it.

It sits between the requester ports and the FPU's enable_i/stall_i/fpu_ready_o/result_valid_o interface.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
C_OP, 32, operand/result width
C_CMD, 4, FPU operator width
C_RM, 2, rounding-mode width
ID_W, 1 (derived = clog2(NUM_REQ), min 1), owner-ID width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid_i  in  NUM_REQ  per-requester request valid
req_ready_o  out  NUM_REQ  per-requester accept (one-hot or zero)
req_op_a_i  in  NUM_REQ*C_OP  packed operand A, requester k at [k*C_OP +: C_OP]
req_op_b_i  in  NUM_REQ*C_OP  packed operand B
req_rm_i  in  NUM_REQ*C_RM  packed rounding mode
req_cmd_i  in  NUM_REQ*C_CMD  packed operator (ADD=0 … FNMSUB=B)
resp_valid_o  out  NUM_REQ  one-hot result valid to owner
resp_result_o  out  C_OP  result, shared bus, qualified by resp_valid_o
stall_i  in  1  pipeline stall; freezes BUSY and RESP
busy_o  out  1  high in BUSY or RESP
owner_o  out  ID_W  ID of current/last owner
fpu_operand_a_o  out  C_OP  to FPU operand_a_i
fpu_operand_b_o  out  C_OP  to FPU operand_b_i
fpu_rounding_mode_o  out  C_RM  to FPU rounding_mode_i
fpu_operator_o  out  C_CMD  to FPU operator_i
fpu_enable_o  out  1  to FPU enable_i
fpu_stall_o  out  1  to FPU stall_i (= stall_i)
fpu_result_i  in  C_OP  from FPU result_o
fpu_ready_i  in  1  from FPU fpu_ready_o
fpu_result_valid_i  in  1  from FPU result_valid_o

Behaviour:
- States and transitions:
  - IDLE → BUSY when any request is valid and fpu_ready_i is high.
  - BUSY → RESP when fpu_result_valid_i && !stall_i.
  - RESP → IDLE when !stall_i.
- IDLE behaviour:
  - The round-robin pick g is the first k with req_valid_i[k] set, searching from (last_grant+1) mod NUM_REQ.
  - req_ready_o[g]=1 combinationally, in the same cycle.
  - On accept, latch operands, rm and cmd of g into operand registers, latch owner=g and last_grant=g.
- BUSY: fpu_enable_o=1; FPU inputs driven from the registers, stable for the whole operation.
- RESP: resp_valid_o[owner]=1 and resp_result_o=result register, held while stall_i=1.
- Latency, no stall: accept in cycle 0, enable in cycles 1–2, FPU result_valid in cycle 2, resp_valid in cycle 3. Throughput is 1 op per 4 cycles.
- req_ready_o=0 outside IDLE. A requester holds valid and payload stable until accepted; the arbiter never drops a pending request.
- Starvation bound: with all requesters continuously valid, each is granted once per NUM_REQ operations.
- stall_i in BUSY:
  - fpu_enable_o stays 1 and fpu_stall_o=1, so the FPU counter freezes.
  - The arbiter does not leave BUSY even if fpu_result_valid_i is high.
- stall_i in IDLE: arbitration continues; an accept is allowed.
- fpu_ready_i=0 in IDLE: no grant.
- When fpu_result_valid_i is 1 outside BUSY, the arbiter ignores it.
- Reset (including mid-operation):
  - state=IDLE; last_grant=NUM_REQ-1, so requester 0 has first priority.
  - owner=0; all outputs 0 except fpu_stall_o, which follows stall_i.
  - Operand and result registers cleared to 0.
- The FPU's rst_n is tied to ~rst at integration, so an aborted operation does not leave the FPU counter mid-count.
- Widths: packed-slice indexing only. ID_W is clamped to ≥1 for NUM_REQ=1; in that case the arbiter always grants requester 0.

Decomposition:
- Shared Verilog include fpu_defines: the C_CMD/C_RM/C_OP constants and command codes, plus the arbiter state encodings IDLE=2'd0, BUSY=2'd1, RESP=2'd2.
- Sub-module rr_picker: combinational round-robin pick. Inputs: req vector and last_grant. Outputs: one-hot grant, grant ID and any_valid. Reusable by other shared-unit arbiters.

Test Plan:
- Single op: requester 0 issues ADD 0x3F800000 + 0x40000000, rm=0 → req_ready_o[0] in cycle 0, fpu_enable_o in cycles 1–2, resp_valid_o=2'b01 in cycle 3 with result 0x40400000, busy_o low in cycle 4.
- Contention, NUM_REQ=2: both valid continuously with MUL operations → grants alternate 0,1,0,1; each resp_valid_o goes only to the issuing requester; no request lost.
- Stall: stall_i=1 for 3 cycles starting in cycle 2 of BUSY → FPU inputs stable, fpu_stall_o=1, resp delayed by 3 cycles with the correct result. Stall in RESP → resp_valid_o held until stall_i=0.
- fpu_ready_i forced 0 in IDLE with req_valid_i=2'b10 → no req_ready_o. After fpu_ready_i rises, grant goes to requester 1 next cycle.
- Reset mid-BUSY: assert rst in cycle 1 → next cycle state IDLE, fpu_enable_o=0, resp_valid_o=0. The next simultaneous request from both requesters grants requester 0 first.
- Spurious fpu_result_valid_i=1 in IDLE → no resp_valid_o.
